mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter and sequencer that shares one combinational 8x8 unsigned multiplier among `NREQ` requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake and registers the operands into the multiplier. It then returns the registered 16-bit product, tagged with the requester index, on a single response channel with backpressure. It sits between the multiplier-comparison datapath and the clients that need products, so the multiplier designs can be swapped in under a real shared-resource load.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, `$clog2(NREQ)`, response tag width (minimum 1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero)
- `req_a`  in  NREQ*8  packed multiplicands; requester i at [8i+7:8i]
- `req_b`  in  NREQ*8  packed multipliers; same packing
- `resp_valid`  out  1  product valid
- `resp_ready`  in  1  consumer accept
- `resp_prod`  out  16  unsigned product a*b
- `resp_id`  out  IDW  index of the requester that issued the operation
- `busy`  out  1  high in every state except IDLE
- `op_count`  out  16  completed responses, saturating at 16'hFFFF

## Operation
- FSM states:
  - IDLE: grant one requester, if any.
  - CALC: the product propagates through the multiplier.
  - RESP: hold the response until it is accepted.
- IDLE, at least one `req_valid`:
  - Grant the first valid requester, searching from `last+1` modulo NREQ.
  - Drive `req_ready` one-hot to that requester (combinational from `req_valid` and state).
  - On the clock edge, capture `req_a`/`req_b`/id into operand registers, set `last` to the winner, go to CALC.
- IDLE, no `req_valid`: `req_ready` = 0, stay in IDLE.
- CALC: register the multiplier output into `resp_prod`, go to RESP. `req_ready` = 0.
- RESP:
  - `resp_valid` = 1. `resp_prod` and `resp_id` are stable until the handshake.
  - On `resp_valid & resp_ready`: go to IDLE and increment `op_count` (no increment at FFFF).
  - No new grant is made in this cycle.
- `req_ready` is 0 in CALC and RESP. Requesters may drop or change `req_valid` freely while not granted; the arbiter does not latch requests.
- Arithmetic: unsigned 8x8 -> 16 bit, full precision. 255*255 = 65025 (16'hFE01).
- Round-robin fairness: a continuously requesting requester waits at most NREQ-1 grants.

## Timing
- Reset (async assert, synchronous deassert at the boundary):
  - state = IDLE; `req_ready` = 0; `resp_valid` = 0; `resp_prod` = 0; `resp_id` = 0; `busy` = 0; `op_count` = 0.
  - `last` = NREQ-1, so requester 0 has first priority.
- Accept at edge N (handshake sampled) -> CALC in cycle N+1 -> `resp_valid` high from edge N+2.
- Minimum issue interval is 3 cycles: a response accepted at edge M allows the next grant in cycle M+1, captured at edge M+2.
- Reset mid-operation discards the in-flight operation: no response, no count.
- Operands are sampled only at the grant edge. Input changes in CALC/RESP do not affect the product.

## Structure
- The shared package holds:
  - State encoding typedef (IDLE, CALC, RESP).
  - Operand width constant (8).
  - Product width constant (16).
  - Counter saturation constant.
- One sub-module: the round-robin priority picker `rr_pick` (inputs: `req` vector and `last`; outputs: one-hot grant and index). It is reused by later shared-resource blocks.
- The multiplier is instantiated as-is (`array_mult_8bit`) on the operand registers. Its implementation is swappable by the comparison flow; the port contract (a, b, prod) is fixed.

## Test plan
- Reset, then requester 1 issues a=12, b=13 -> `req_ready`=4'b0010 in that cycle; `resp_valid` rises 2 cycles later with prod=156, id=1; `op_count`=1 after the handshake.
- All 4 requesters are held valid for 8 operations with distinct operands -> grant order 0,1,2,3,0,1,2,3; every product is correct.
- a=255, b=255 -> prod=16'hFE01; a=0, b=200 -> prod=0.
- `resp_ready` held low for 5 cycles in RESP -> `resp_valid`, prod and id are stable; no `req_ready` pulses; exactly one count when released.
- `rst` asserted one cycle after a grant -> outputs take reset values immediately; no response; `op_count`=0; the next grant goes to requester 0.
- Force `op_count` near saturation by running 65537 operations (or `NREQ`=2 fast run) -> `op_count` stays at 16'hFFFF.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// mult_share_arb_pkg: shared state encoding and datapath widths for the multiplier arbiter
package mult_share_arb_pkg;
  localparam int OPW = 8;
  localparam int PRODW = 16;
  localparam logic [PRODW-1:0] CNT_MAX = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
endpackage

// File: rtl/array_mult_8bit.sv
// array_mult_8bit: combinational unsigned 8x8 shift-add array multiplier
module array_mult_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);
  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) prod = prod + (b[i] ? ({8'd0, a} << i) : 16'd0);
  end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority picker, searching upward from last+1 modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sequencer sharing one 8x8 multiplier among NREQ requesters
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [PRODW-1:0]     resp_prod,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy,
  output logic [15:0]          op_count
);
  state_e state_q, state_d;
  logic [OPW-1:0] a_q, b_q;
  logic [IDW-1:0] id_q, last_q, gnt_idx;
  logic [PRODW-1:0] prod_q, mult_prod, cnt_q;
  logic [NREQ-1:0] gnt;
  logic take, done;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (.req(req_valid), .last(last_q), .gnt(gnt), .idx(gnt_idx));
  array_mult_8bit u_mult (.a(a_q), .b(b_q), .prod(mult_prod));

  always_comb begin
    take = (state_q == IDLE) && |req_valid;
    done = (state_q == RESP) && resp_ready;
    req_ready = (state_q == IDLE) ? gnt : '0;
    state_d = (state_q == IDLE) ? (take ? CALC : IDLE) :
              (state_q == CALC) ? RESP : (done ? IDLE : RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      last_q <= IDW'(NREQ - 1);
      prod_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        a_q <= req_a[gnt_idx*OPW +: OPW];
        b_q <= req_b[gnt_idx*OPW +: OPW];
        id_q <= gnt_idx;
        last_q <= gnt_idx;
      end
      if (state_q == CALC) prod_q <= mult_prod;
      if (done && cnt_q != CNT_MAX) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign busy = (state_q != IDLE);
  assign resp_prod = prod_q;
  assign resp_id = id_q;
  assign op_count = cnt_q;
endmodule
